mod_mul_arbiter: RTL and testbench
==================================

// Module: mod_mul_arbiter
// PURPOSE
//   Shares one 3-cycle pipelined ML-KEM modular multiplier (mod_mul, q=3329) among NUM_REQ requesters
//   (NTT butterfly, basecase-mul, compress units). Round-robin issues at most one op per cycle, tags each
//   issue with its requester index through a shift pipeline, routes each product back to its owner.
//   Instantiates mod_mul internally; the only path to the multiplier in the poly-arith datapath.
// PARAMETERS
//   NUM_REQ      2    number of requesters, 1..8
//   MUL_LATENCY  3    mod_mul latency in cycles; must match mod_mul (tag pipeline depth)
//   TAG_W        $clog2(NUM_REQ) (min 1)  requester-index width
// PORTS
//   clk            in   1            clock, rising edge
//   rst            in   1            asynchronous, active-high reset
//   req_valid_i    in   NUM_REQ      per-requester operand valid
//   req_ready_o    out  NUM_REQ      per-requester accept (one-hot or zero)
//   req_op1_i      in   NUM_REQ x 12 coeff_t operand A per requester, 0..3328
//   req_op2_i      in   NUM_REQ x 12 coeff_t operand B per requester, 0..3328
//   rsp_valid_o    out  NUM_REQ      one-hot result strobe, 1 cycle
//   rsp_result_o   out  12           coeff_t (A*B) mod 3329, shared bus, valid with rsp_valid_o
//   busy_o         out  1            any op in flight (tag pipeline non-empty)
//   err_o          out  1            sticky: mod_mul valid_o disagreed with tag pipeline
//   grant_cnt_o    out  NUM_REQ x 16 per-requester issue counters (see CONFIGURATION)
// BEHAVIOUR
//   Reset: req_ready_o=0, rsp_valid_o=0, rsp_result_o=0, busy_o=0, err_o=0, grant_cnt_o=0, RR ptr=0,
//     tag pipeline valids cleared, mod_mul pipeline reset via same rst; in-flight ops discarded, no response.
//   Arbitration (combinational): grant = first i with req_valid_i[i]=1 scanning ptr, ptr+1, .. wrap to 0.
//     req_ready_o[i]=1 only for granted i; all zero when no valid. ready may depend on valid.
//   Issue: handshake on req_valid_i[g]&req_ready_o[g] at clock edge T; mod_mul valid_i=1, op1/op2 muxed
//     from requester g in same cycle. At edge T ptr <= (g+1) mod NUM_REQ (NUM_REQ-1 wraps to 0).
//     No valid -> ptr unchanged. NUM_REQ=1: ready = valid, ptr fixed 0.
//   Throughput: 1 issue/cycle sustained; no bubbles between back-to-back handshakes of any requesters.
//   Requester holds valid and operands stable until accepted; arbiter registers nothing before handshake.
//   Tag pipeline: MUL_LATENCY stages of {vld,tag}; stage0 loaded at handshake edge, shifts every cycle.
//   Response: rsp_valid_o[tag]=1 when last-stage vld=1 AND mod_mul valid_o=1, i.e. exactly MUL_LATENCY
//     cycles after issue edge; rsp_result_o = mod_mul result_o. No response backpressure: requester must
//     consume on strobe. rsp_result_o holds last value when no strobe.
//   Ordering: results return in issue order; per-requester order preserved.
//   busy_o = OR of tag pipeline vld bits (registered).
//   err_o set when last-stage vld != mod_mul valid_o in any cycle; cleared only by rst; mismatch cycle
//     emits no rsp_valid_o.
//   Simultaneous issue and response in same cycle fully supported (pipeline shift + load).
// CONFIGURATION
//   MOD_MUL_ARB_STATS_EN defined: grant_cnt_o[i] +1 on each handshake of requester i, saturates at 16'hFFFF,
//     cleared by rst. Not defined: grant_cnt_o tied to 0, counters not synthesised; function otherwise identical.
// TESTING
//   Single req0: (3328,3328) handshake at edge T -> rsp_valid_o=01, rsp_result_o=1 at T+3; busy_o high T+1..T+3.
//   All NUM_REQ=2 valid continuously 6 cycles, ptr=0 -> grants 0,1,0,1,0,1; results strobes alternate 01/10, no gaps.
//   req1 valid alone then req0 joins while ptr=0 after req1 grant -> req0 granted next; no requester starved >NUM_REQ-1 cycles.
//   500 random pairs 0..3328 from both requesters with random valid gaps -> every product = (a*b)%3329, correct owner, in order, err_o=0.
//   rst asserted 1 cycle after 2 issues in flight -> outputs 0 immediately, no rsp_valid_o afterward, ptr=0.
//   With MOD_MUL_ARB_STATS_EN: 10 req0 + 7 req1 issues -> grant_cnt_o = {7,10}; without macro -> 0.

Source files
------------

// File: rtl/mod_mul_arbiter.sv
// mod_mul_arbiter: round-robin share of one 3-cycle mod-3329 multiplier; MOD_MUL_ARB_STATS_EN adds grant counters
module mod_mul (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  input  logic [11:0] a_i,
  input  logic [11:0] b_i,
  output logic        valid_o,
  output logic [11:0] result_o
);
  logic [2:0]  v;
  logic [23:0] p;
  logic [12:0] t;
  // Barrett with m = floor(2^24/3329) leaves a remainder below 2q, fixed by one subtract
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      v        <= '0;
      p        <= '0;
      t        <= '0;
      result_o <= '0;
    end else begin
      v        <= {v[1:0], valid_i};
      p        <= 24'(a_i) * 24'(b_i);
      t        <= 13'(p - 24'(13'((37'(p) * 37'd5039) >> 24)) * 24'd3329);
      result_o <= (t >= 13'd3329) ? 12'(t - 13'd3329) : t[11:0];
    end
  assign valid_o = v[2];
endmodule

module mod_mul_arbiter #(
  parameter int NUM_REQ     = 2,
  parameter int MUL_LATENCY = 3,
  parameter int TAG_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  input  logic [NUM_REQ-1:0][11:0]  req_op1_i,
  input  logic [NUM_REQ-1:0][11:0]  req_op2_i,
  output logic [NUM_REQ-1:0]        rsp_valid_o,
  output logic [11:0]               rsp_result_o,
  output logic                      busy_o,
  output logic                      err_o,
  output logic [NUM_REQ-1:0][15:0]  grant_cnt_o
);
  logic [TAG_W-1:0]                  ptr, g;
  logic [TAG_W:0]                    idx;
  logic                              hs, mul_v;
  logic [11:0]                       mul_r;
  logic [MUL_LATENCY-1:0]            tv;
  logic [MUL_LATENCY-1:0][TAG_W-1:0] tt;

  always_comb begin
    g   = '0;
    hs  = 1'b0;
    idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = {1'b0, ptr} + (TAG_W+1)'(k);
      idx = (idx >= (TAG_W+1)'(NUM_REQ)) ? idx - (TAG_W+1)'(NUM_REQ) : idx;
      if (!hs && req_valid_i[idx[TAG_W-1:0]]) begin
        g  = idx[TAG_W-1:0];
        hs = 1'b1;
      end
    end
  end

  assign req_ready_o = NUM_REQ'(hs) << g;

  mod_mul u_mul (
    .clk      (clk),
    .rst      (rst),
    .valid_i  (hs),
    .a_i      (req_op1_i[g]),
    .b_i      (req_op2_i[g]),
    .valid_o  (mul_v),
    .result_o (mul_r)
  );

  // the tag pipeline mirrors the multiplier so each product finds its owner
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ptr          <= '0;
      tv           <= '0;
      tt           <= '0;
      busy_o       <= 1'b0;
      err_o        <= 1'b0;
      rsp_valid_o  <= '0;
      rsp_result_o <= '0;
    end else begin
      if (hs) ptr <= (g == TAG_W'(NUM_REQ-1)) ? '0 : g + 1'b1;
      tv[0] <= hs;
      tt[0] <= g;
      for (int s = 1; s < MUL_LATENCY; s++) begin
        tv[s] <= tv[s-1];
        tt[s] <= tt[s-1];
      end
      busy_o      <= |tv;
      err_o       <= err_o | (tv[MUL_LATENCY-1] != mul_v);
      rsp_valid_o <= (tv[MUL_LATENCY-1] && mul_v) ? NUM_REQ'(1) << tt[MUL_LATENCY-1] : '0;
      if (tv[MUL_LATENCY-1] && mul_v) rsp_result_o <= mul_r;
    end

`ifdef MOD_MUL_ARB_STATS_EN
  logic [NUM_REQ-1:0][15:0] cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else
      for (int i = 0; i < NUM_REQ; i++)
        if (hs && g == TAG_W'(i) && cnt[i] != 16'hFFFF) cnt[i] <= cnt[i] + 16'd1;
  assign grant_cnt_o = cnt;
`else
  assign grant_cnt_o = '0;
`endif
endmodule

// File: tb/tb_mod_mul_arbiter.sv
// tb_mod_mul_arbiter: directed checks of the two-requester multiplier arbiter
module tb_mod_mul_arbiter;
  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       req_valid_i, req_ready_o, rsp_valid_o;
  logic [1:0][11:0] req_op1_i, req_op2_i;
  logic [11:0]      rsp_result_o;
  logic             busy_o, err_o;
  logic [1:0][15:0] grant_cnt_o;
  int               vectors = 0, miscompares = 0;
  logic             hv [4];
  logic [1:0]       ho [4];
  logic [11:0]      hr [4];
  logic [11:0]      last_res;
  logic [1:0]       pend;
  logic             rr;
  logic [1:0]       er;

  mod_mul_arbiter #(.NUM_REQ(2), .MUL_LATENCY(3)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_op1_i    (req_op1_i),
    .req_op2_i    (req_op2_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_result_o (rsp_result_o),
    .busy_o       (busy_o),
    .err_o        (err_o),
    .grant_cnt_o  (grant_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_hist();
    for (int k = 0; k < 4; k++) begin
      hv[k] = 1'b0;
      ho[k] = 2'b00;
      hr[k] = 12'd0;
    end
    last_res = 12'd0;
  endtask

  // one clock: check grant, record the expected product, then check the response due now
  task automatic step(input logic [1:0] exp_rdy);
    #1;
    chk("ready", req_ready_o, exp_rdy);
    for (int k = 3; k > 0; k--) begin
      hv[k] = hv[k-1];
      ho[k] = ho[k-1];
      hr[k] = hr[k-1];
    end
    hv[0] = |exp_rdy;
    ho[0] = exp_rdy;
    hr[0] = exp_rdy[1] ? 12'((int'(req_op1_i[1]) * int'(req_op2_i[1])) % 3329)
                       : 12'((int'(req_op1_i[0]) * int'(req_op2_i[0])) % 3329);
    @(posedge clk);
    #1;
    chk("rsp_valid", rsp_valid_o, hv[3] ? ho[3] : 2'b00);
    if (hv[3]) last_res = hr[3];
    chk("rsp_result", rsp_result_o, last_res);
    chk("busy", busy_o, hv[1] | hv[2] | hv[3]);
    chk("err", err_o, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    chk("rst_rsp_valid", rsp_valid_o, 0);
    chk("rst_result", rsp_result_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_cnt", grant_cnt_o, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    clear_hist();
  endtask

  initial begin
    rst = 1'b1;
    req_valid_i = 2'b00;
    req_op1_i = '0;
    req_op2_i = '0;
    clear_hist();
    do_reset();
    chk("rst_ready", req_ready_o, 0);

    // single requester 0: 3328*3328 mod 3329 = 1 three edges after issue
    req_valid_i = 2'b01;
    req_op1_i[0] = 12'd3328;
    req_op2_i[0] = 12'd3328;
    step(2'b01);
    req_valid_i = 2'b00;
    repeat (3) step(2'b00);
    chk("sq_result", rsp_result_o, 1);
    chk("sq_strobe", rsp_valid_o, 2'b01);
    step(2'b00);
    chk("sq_hold", rsp_result_o, 1);

    // both valid for 6 cycles from ptr 0: strict alternation
    do_reset();
    req_valid_i = 2'b11;
    req_op1_i[0] = 12'd100; req_op2_i[0] = 12'd200;
    req_op1_i[1] = 12'd3000; req_op2_i[1] = 12'd17;
    for (int k = 0; k < 6; k++) begin
      step(k[0] ? 2'b10 : 2'b01);
      if (k[0]) req_op1_i[1] = req_op1_i[1] + 12'd11;
      else req_op1_i[0] = req_op1_i[0] + 12'd7;
    end
    req_valid_i = 2'b00;
    repeat (3) step(2'b00);

    // requester 1 alone, then requester 0 joins and is served next
    do_reset();
    req_valid_i = 2'b10;
    req_op1_i[1] = 12'd1234; req_op2_i[1] = 12'd2345;
    step(2'b10);
    req_valid_i = 2'b11;
    req_op1_i[0] = 12'd55; req_op2_i[0] = 12'd3328;
    req_op1_i[1] = 12'd2; req_op2_i[1] = 12'd1665;
    step(2'b01);
    step(2'b10);
    req_valid_i = 2'b00;
    repeat (3) step(2'b00);

    // random operands with random valid gaps; requesters hold until accepted
    do_reset();
    pend = 2'b00;
    rr = 1'b0;
    for (int n = 0; n < 500; n++) begin
      for (int i = 0; i < 2; i++)
        if (!pend[i] && $urandom_range(0, 2) != 0) begin
          pend[i] = 1'b1;
          req_op1_i[i] = 12'($urandom_range(0, 3328));
          req_op2_i[i] = 12'($urandom_range(0, 3328));
        end
      req_valid_i = pend;
      er = (pend == 2'b11) ? (rr ? 2'b10 : 2'b01) : pend;
      step(er);
      if (er != 2'b00) begin
        pend = pend & ~er;
        rr = er[0];
      end
      req_valid_i = pend;
    end
    req_valid_i = 2'b00;
    repeat (3) step(2'b00);

    // reset with two ops in flight: nothing comes back, ptr returns to 0
    do_reset();
    req_valid_i = 2'b10;
    req_op1_i[1] = 12'd5; req_op2_i[1] = 12'd6;
    step(2'b10);
    req_valid_i = 2'b01;
    req_op1_i[0] = 12'd9; req_op2_i[0] = 12'd9;
    step(2'b01);
    req_valid_i = 2'b00;
    step(2'b00);
    rst = 1'b1;
    #1;
    chk("mid_rsp_valid", rsp_valid_o, 0);
    chk("mid_busy", busy_o, 0);
    chk("mid_result", rsp_result_o, 0);
    chk("mid_err", err_o, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    clear_hist();
    repeat (4) step(2'b00);
    req_valid_i = 2'b11;
    step(2'b01);
    req_valid_i = 2'b10;
    step(2'b10);
    req_valid_i = 2'b00;
    repeat (3) step(2'b00);

    // 10 grants to requester 0, 7 to requester 1
    do_reset();
    req_valid_i = 2'b11;
    for (int k = 0; k < 14; k++) step(k[0] ? 2'b10 : 2'b01);
    req_valid_i = 2'b01;
    repeat (3) step(2'b01);
    req_valid_i = 2'b00;
    repeat (3) step(2'b00);
`ifdef MOD_MUL_ARB_STATS_EN
    chk("grant_cnt", grant_cnt_o, {16'd7, 16'd10});
`else
    chk("grant_cnt", grant_cnt_o, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
